// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit sequencer with baud bit timer
// Optional line-break generator is compiled in with UART_TX_BREAK_EN.
module uart_tx_ctrl #(
  parameter int DIV_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              tx_en,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop2,
  input  logic              fifo_rempty,
  input  logic [DATA_W-1:0] fifo_data,
`ifdef UART_TX_BREAK_EN
  input  logic              tx_break,
`endif
  output logic              fifo_rinc,
  output logic              txd,
  output logic              tx_busy,
  output logic              tx_done
);

  // Bit counter must hold 0..DATA_W-1 in DATA and 0..1 in STOP
  localparam int BC_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_W - 1);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_LOAD     = 4'd2;
  localparam logic [3:0] ST_START    = 4'd3;
  localparam logic [3:0] ST_DATA     = 4'd4;
  localparam logic [3:0] ST_PARITY   = 4'd5;
  localparam logic [3:0] ST_STOP     = 4'd6;
`ifdef UART_TX_BREAK_EN
  localparam logic [3:0] ST_BREAK    = 4'd7;
  localparam logic [3:0] ST_BRK_MARK = 4'd8;
`endif

  logic [3:0]        state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [BC_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              pe_q, pe_d;
  logic              s2_q, s2_d;
  logic              par_q, par_d;
  logic              txd_d;
  logic              rinc_d;
  logic              busy_d;
  logic              done_d;
  logic              fetch_ok;
  logic              bit_end;
  logic [BC_W-1:0]   stop_last;

  assign fetch_ok  = tx_en && !fifo_rempty;
  assign bit_end   = (cnt_q == '0);
  assign stop_last = s2_q ? BC_W'(1) : '0;

  // Next-state, bit timer, bit counter and shift register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    div_d   = div_q;
    pe_d    = pe_q;
    s2_d    = s2_q;
    par_d   = par_q;
    case (state_q)
      ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (tx_break) state_d = ST_BREAK;
        else
`endif
        if (fetch_ok) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        // Frame config is frozen here; later register writes wait for the next frame
        shift_d = fifo_data;
        div_d   = baud_div;
        pe_d    = parity_en;
        s2_d    = stop2;
        par_d   = (^fifo_data) ^ parity_odd;
        cnt_d   = baud_div;
        state_d = ST_START;
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = div_q;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = div_q;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = pe_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_d   = bit_q + BC_W'(1);
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          cnt_d   = div_q;
          bit_d   = '0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q != stop_last) begin
            bit_d = bit_q + BC_W'(1);
            cnt_d = div_q;
          end else begin
`ifdef UART_TX_BREAK_EN
            if (tx_break) state_d = ST_BREAK;
            else
`endif
            if (fetch_ok) state_d = ST_FETCH;
            else          state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        // Mark time after a break uses the live divisor, not the frame latch
        if (!tx_break) begin
          state_d = ST_BRK_MARK;
          cnt_d   = baud_div;
          bit_d   = '0;
        end
      end
      ST_BRK_MARK: begin
        if (bit_end) begin
          if (bit_q == '0) begin
            bit_d = BC_W'(1);
            cnt_d = baud_div;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state so outputs can be registered
  always_comb begin
    case (state_d)
      ST_START:    txd_d = 1'b0;
      ST_DATA:     txd_d = shift_d[0];
      ST_PARITY:   txd_d = par_q;
`ifdef UART_TX_BREAK_EN
      ST_BREAK:    txd_d = 1'b0;
`endif
      default:     txd_d = 1'b1;
    endcase
    rinc_d = (state_d == ST_FETCH);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_STOP) && (cnt_d == '0) && (bit_d == stop_last);
  end

  // State and registered outputs; reset drops the partial frame and idles the line
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      div_q     <= '0;
      pe_q      <= 1'b0;
      s2_q      <= 1'b0;
      par_q     <= 1'b0;
      txd       <= 1'b1;
      fifo_rinc <= 1'b0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      pe_q      <= pe_d;
      s2_q      <= s2_d;
      par_q     <= par_d;
      txd       <= txd_d;
      fifo_rinc <= rinc_d;
      tx_busy   <= busy_d;
      tx_done   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;

  logic        clk;
  logic        rst_;
  logic        tx_en;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic        stop2;
  logic        fifo_rempty;
  logic [7:0]  fifo_data;
  logic        fifo_rinc;
  logic        txd;
  logic        tx_busy;
  logic        tx_done;
`ifdef UART_TX_BREAK_EN
  logic        tx_break;
`endif

  int errors = 0;
  int checks = 0;

  // FIFO model: bytes written by the stimulus, popped by the DUT strobe
  logic [7:0] mem [0:255];
  int push_cnt = 0;
  int pop_cnt = 0;
  int underflow_cnt = 0;

  assign fifo_rempty = (push_cnt == pop_cnt);

  uart_tx_ctrl #(.DIV_W(16), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_        (rst_),
    .tx_en       (tx_en),
    .baud_div    (baud_div),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .stop2       (stop2),
    .fifo_rempty (fifo_rempty),
    .fifo_data   (fifo_data),
`ifdef UART_TX_BREAK_EN
    .tx_break    (tx_break),
`endif
    .fifo_rinc   (fifo_rinc),
    .txd         (txd),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered FIFO read port
  always @(posedge clk) begin
    if (fifo_rinc) begin
      if (push_cnt == pop_cnt) begin
        underflow_cnt <= underflow_cnt + 1;
      end else begin
        fifo_data <= mem[pop_cnt[7:0]];
        pop_cnt   <= pop_cnt + 1;
      end
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[push_cnt[7:0]] = b;
    push_cnt = push_cnt + 1;
  endtask

  // Frame as the line should carry it: start, data LSB first, optional parity, stop bit(s)
  function automatic void model_frame(input logic [7:0] b, input logic pe, input logic po,
                                      input logic s2, output logic [11:0] bits, output int len);
    bits = '1;
    len = 0;
    bits[len] = 1'b0;
    len++;
    for (int i = 0; i < 8; i++) begin
      bits[len] = b[i];
      len++;
    end
    if (pe) begin
      bits[len] = (^b) ^ po;
      len++;
    end
    bits[len] = 1'b1;
    len++;
    if (s2) begin
      bits[len] = 1'b1;
      len++;
    end
  endfunction

  // Waits for a start bit, then checks each bit over div+1 clocks and the tx_done pulse
  task automatic expect_frame(input logic [11:0] bits, input int len, input int div, output int waited);
    int w;
    int dcnt;
    logic dlast;
    logic badv;
    w = 0;
    dlast = 1'b0;
    while (txd !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    waited = w;
    if (txd !== 1'b0) begin
      check("start bit timeout", {31'd0, txd}, 32'd0);
      return;
    end
    dcnt = 0;
    for (int i = 0; i < len; i++) begin
      badv = bits[i];
      for (int k = 0; k <= div; k++) begin
        if (!(i == 0 && k == 0)) @(negedge clk);
        if (txd !== bits[i]) badv = txd;
        if (tx_done === 1'b1) dcnt++;
        dlast = tx_done;
      end
      check($sformatf("frame bit %0d", i), {31'd0, badv}, {31'd0, bits[i]});
    end
    check("tx_done pulse count", dcnt, 1);
    check("tx_done on last stop clock", {31'd0, dlast}, 32'd1);
  endtask

  typedef struct {
    logic [7:0]  data;
    int          div;
    logic        pe;
    logic        po;
    logic        s2;
    logic [11:0] bits;
    int          len;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int w;
    int p0;
    int act;
    int len;
    logic [11:0] bits;
    logic [7:0] bb [3];
    int dv;

    tbl[0] = '{8'hA5, 3, 1'b0, 1'b0, 1'b0, 12'hF4A, 10};
    tbl[1] = '{8'h07, 3, 1'b1, 1'b0, 1'b0, 12'hE0E, 11};
    tbl[2] = '{8'h07, 3, 1'b1, 1'b1, 1'b0, 12'hC0E, 11};
    tbl[3] = '{8'h07, 3, 1'b1, 1'b0, 1'b1, 12'hE0E, 12};
    tbl[4] = '{8'h00, 0, 1'b0, 1'b0, 1'b0, 12'hE00, 10};
    tbl[5] = '{8'hFF, 0, 1'b1, 1'b1, 1'b1, 12'hFFE, 12};

    rst_ = 1'b0;
    tx_en = 1'b0;
    baud_div = 16'd3;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    stop2 = 1'b0;
`ifdef UART_TX_BREAK_EN
    tx_break = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset txd", {31'd0, txd}, 32'd1);
    check("reset tx_busy", {31'd0, tx_busy}, 32'd0);
    check("reset tx_done", {31'd0, tx_done}, 32'd0);
    check("reset fifo_rinc", {31'd0, fifo_rinc}, 32'd0);
    rst_ = 1'b1;
    repeat (2) @(negedge clk);
    check("idle no read while empty", pop_cnt + underflow_cnt, 0);

    // Start latency: FETCH, LOAD, then start bit
    tx_en = 1'b1;
    push(8'hA5);
    @(negedge clk);
    check("fifo_rinc in FETCH", {31'd0, fifo_rinc}, 32'd1);
    check("tx_busy in FETCH", {31'd0, tx_busy}, 32'd1);
    @(negedge clk);
    check("fifo_rinc single pulse", {31'd0, fifo_rinc}, 32'd0);
    check("txd high in LOAD", {31'd0, txd}, 32'd1);
    @(negedge clk);
    check("txd low at START", {31'd0, txd}, 32'd0);
    expect_frame(12'hF4A, 10, 3, w);
    repeat (2) @(negedge clk);
    check("busy clear after frame", {31'd0, tx_busy}, 32'd0);
    check("one read for one byte", pop_cnt, 1);

    // Table of hand-computed frames
    for (int t = 0; t < 6; t++) begin
      baud_div = 16'(tbl[t].div);
      parity_en = tbl[t].pe;
      parity_odd = tbl[t].po;
      stop2 = tbl[t].s2;
      p0 = pop_cnt;
      push(tbl[t].data);
      expect_frame(tbl[t].bits, tbl[t].len, tbl[t].div, w);
      repeat (2) @(negedge clk);
      check($sformatf("tbl%0d reads", t), pop_cnt - p0, 1);
      check($sformatf("tbl%0d busy after", t), {31'd0, tx_busy}, 32'd0);
    end

    // Back-to-back frames at one clock per bit
    baud_div = 16'd0;
    parity_en = 1'b0;
    stop2 = 1'b0;
    p0 = pop_cnt;
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    model_frame(8'h00, 1'b0, 1'b0, 1'b0, bits, len);
    expect_frame(bits, len, 0, w);
    model_frame(8'hFF, 1'b0, 1'b0, 1'b0, bits, len);
    expect_frame(bits, len, 0, w);
    check("b2b gap frame2", w, 3);
    model_frame(8'h55, 1'b0, 1'b0, 1'b0, bits, len);
    expect_frame(bits, len, 0, w);
    check("b2b gap frame3", w, 3);
    repeat (4) @(negedge clk);
    check("b2b reads", pop_cnt - p0, 3);
    check("b2b busy after", {31'd0, tx_busy}, 32'd0);

    // Random single frames against the model
    for (int it = 0; it < 12; it++) begin
      dv = int'($urandom_range(0, 3));
      baud_div = 16'(dv);
      parity_en = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      stop2 = 1'($urandom_range(0, 1));
      bb[0] = 8'($urandom_range(0, 255));
      model_frame(bb[0], parity_en, parity_odd, stop2, bits, len);
      push(bb[0]);
      expect_frame(bits, len, dv, w);
      repeat (2) @(negedge clk);
    end

    // Random back-to-back bursts
    for (int bi = 0; bi < 3; bi++) begin
      dv = int'($urandom_range(0, 2));
      baud_div = 16'(dv);
      parity_en = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      stop2 = 1'($urandom_range(0, 1));
      for (int j = 0; j < 3; j++) begin
        bb[j] = 8'($urandom_range(0, 255));
        push(bb[j]);
      end
      for (int j = 0; j < 3; j++) begin
        model_frame(bb[j], parity_en, parity_odd, stop2, bits, len);
        expect_frame(bits, len, dv, w);
        if (j > 0) check($sformatf("burst%0d gap%0d", bi, j), w, 3);
      end
      repeat (3) @(negedge clk);
    end

    // Mid-frame divisor change and tx_en drop with two bytes queued
    baud_div = 16'd3;
    parity_en = 1'b0;
    stop2 = 1'b0;
    tx_en = 1'b1;
    p0 = pop_cnt;
    push(8'h3C);
    push(8'h96);
    model_frame(8'h3C, 1'b0, 1'b0, 1'b0, bits, len);
    fork
      expect_frame(bits, len, 3, w);
      begin
        repeat (14) @(negedge clk);
        baud_div = 16'd7;
        tx_en = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("tx_en drop no second read", pop_cnt - p0, 1);
    check("fifo count stays 1", push_cnt - pop_cnt, 1);
    check("idle after tx_en drop", {31'd0, tx_busy}, 32'd0);
    tx_en = 1'b1;
    model_frame(8'h96, 1'b0, 1'b0, 1'b0, bits, len);
    expect_frame(bits, len, 7, w);
    repeat (2) @(negedge clk);

    // Reset during the 4th data bit of an all-zero byte
    baud_div = 16'd3;
    push(8'h00);
    w = 0;
    while (txd !== 1'b0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("reset test start seen", {31'd0, txd}, 32'd0);
    repeat (17) @(negedge clk);
    check("txd low before reset", {31'd0, txd}, 32'd0);
    rst_ = 1'b0;
    #1;
    check("async reset txd", {31'd0, txd}, 32'd1);
    check("async reset busy", {31'd0, tx_busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    p0 = pop_cnt;
    act = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_busy !== 1'b0 || fifo_rinc !== 1'b0) act++;
    end
    check("quiet after reset", act, 0);
    check("no reads after reset", pop_cnt - p0, 0);

`ifdef UART_TX_BREAK_EN
    // Break: 20 clocks low, then two bit periods of mark at baud_div=1
    baud_div = 16'd1;
    tx_break = 1'b1;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txd !== 1'b0 || tx_busy !== 1'b1) act++;
    end
    tx_break = 1'b0;
    check("break low phase", act, 0);
    act = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_busy !== 1'b1) act++;
    end
    check("break mark phase", act, 0);
    @(negedge clk);
    check("break back to idle", {31'd0, tx_busy}, 32'd0);
    check("break txd idle", {31'd0, txd}, 32'd1);
`endif

    check("no fifo underflow", underflow_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
